// File: rtl/low_frequency_apb_if.sv
// B-clock APB bus between the bridge's receiving half (master) and the downstream slave.
// Handshake: a transfer is offered while b_psel=1, b_penable=1 and completes on the edge where b_pready=1.
interface low_frequency_apb_if #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int STRB_WD = 4,
  parameter int PROT_WD = 3
) ();
  logic               b_psel;
  logic               b_penable;
  logic               b_pwrite;
  logic [ADDR_WD-1:0] b_paddr;
  logic [DATA_WD-1:0] b_pwdata;
  logic [PROT_WD-1:0] b_pprot;
  logic [STRB_WD-1:0] b_pstrb;
  logic [DATA_WD-1:0] b_prdata;
  logic               b_pready;

  modport master (
    output b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, b_pprot, b_pstrb,
    input  b_prdata, b_pready
  );

  modport slave (
    input  b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, b_pprot, b_pstrb,
    output b_prdata, b_pready
  );
endinterface

// File: rtl/low_frequency_apb.sv
// Receiving half of the APB async bridge: turns a synchronised request toggle into one
// APB transfer on the B clock and answers with a completion toggle plus read data.
module low_frequency_apb #(
  parameter int                 ADDR_WD     = 32,
  parameter int                 DATA_WD     = 32,
  parameter int                 STRB_WD     = 4,
  parameter int                 PROT_WD     = 3,
  parameter int                 TIMEOUT_CYC = 0,
  parameter logic [DATA_WD-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic               b_pclk,
  input  logic               b_prst_n,
  input  logic               a_apb_req,
  input  logic               write,
  input  logic [ADDR_WD-1:0] addr,
  input  logic [DATA_WD-1:0] wdata,
  input  logic [PROT_WD-1:0] prot,
  input  logic [STRB_WD-1:0] strb,
  output logic               b_ready_req,
  output logic [DATA_WD-1:0] rdata,
  output logic               b_timeout,
  output logic [1:0]         dbg_state,
  low_frequency_apb_if.master apb
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  localparam int CNT_WD = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYC > 0);

  state_t             state;
  logic               q1, q2, q3;
  logic               req_edge;
  logic               pending;
  logic [CNT_WD-1:0]  to_cnt;
  logic               timeout_hit;

  logic               psel_q, penable_q, pwrite_q;
  logic [ADDR_WD-1:0] paddr_q;
  logic [DATA_WD-1:0] pwdata_q;
  logic [PROT_WD-1:0] pprot_q;
  logic [STRB_WD-1:0] pstrb_q;

  assign req_edge    = q2 ^ q3;
  assign timeout_hit = TO_EN && (to_cnt == CNT_LAST) && !apb.b_pready;

  always_ff @(posedge b_pclk or negedge b_prst_n) begin
    if (!b_prst_n) begin
      q1          <= 1'b0;
      q2          <= 1'b0;
      q3          <= 1'b0;
      state       <= IDLE;
      pending     <= 1'b0;
      to_cnt      <= '0;
      b_ready_req <= 1'b0;
      rdata       <= '0;
      b_timeout   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pprot_q     <= '0;
      pstrb_q     <= '0;
    end else begin
      q1        <= a_apb_req;
      q2        <= q1;
      q3        <= q2;
      b_timeout <= 1'b0;
      case (state)
        IDLE: begin
          // Payload is quasi-static: the A side holds it until our completion toggle returns.
          if (req_edge || pending) begin
            pwrite_q  <= write;
            paddr_q   <= addr;
            pwdata_q  <= wdata;
            pprot_q   <= prot;
            pstrb_q   <= strb;
            pending   <= 1'b0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (req_edge) pending <= 1'b1;
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (req_edge) pending <= 1'b1;
          if (apb.b_pready || timeout_hit) begin
            if (!pwrite_q) rdata <= apb.b_pready ? apb.b_prdata : ERR_DATA;
            b_timeout   <= !apb.b_pready;
            b_ready_req <= ~b_ready_req;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            to_cnt      <= '0;
            state       <= IDLE;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign apb.b_psel    = psel_q;
  assign apb.b_penable = penable_q;
  assign apb.b_pwrite  = pwrite_q;
  assign apb.b_paddr   = paddr_q;
  assign apb.b_pwdata  = pwdata_q;
  assign apb.b_pprot   = pprot_q;
  assign apb.b_pstrb   = pstrb_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_low_frequency_apb.sv
// Bench for low_frequency_apb: two instances (timeout 8 and 4) share one request stream;
// a cycle-level transaction model predicts start/completion cycles, read data and timeouts.
module tb_low_frequency_apb;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  prot;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        to;
    int          start;
    int          done;
  } exp_t;

  typedef struct packed {
    int          w;
    logic [31:0] prd;
  } slv_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_apb_req;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  prot;
  logic [3:0]  strb;

  logic        rr8, rr4, to8, to4;
  logic [31:0] rd8, rd4;
  logic [1:0]  st8, st4;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  slv_t slv_q0[$];
  slv_t slv_q1[$];

  // model state (stimulus side)
  int          last_done[2];
  logic [31:0] mrd[2];

  // monitor / slave state
  logic        prev_rr[2], prev_psel[2], prev_pen[2];
  logic [31:0] cur_rd[2];
  logic [31:0] slv_prd[2];
  int          slv_w[2], acnt[2], start_cyc[2];

  low_frequency_apb_if bus8 ();
  low_frequency_apb_if bus4 ();

  low_frequency_apb #(.TIMEOUT_CYC(8)) u_dut8 (
    .b_pclk(clk), .b_prst_n(rst_n), .a_apb_req(a_apb_req), .write(write), .addr(addr),
    .wdata(wdata), .prot(prot), .strb(strb), .b_ready_req(rr8), .rdata(rd8),
    .b_timeout(to8), .dbg_state(st8), .apb(bus8)
  );

  low_frequency_apb #(.TIMEOUT_CYC(4)) u_dut4 (
    .b_pclk(clk), .b_prst_n(rst_n), .a_apb_req(a_apb_req), .write(write), .addr(addr),
    .wdata(wdata), .prot(prot), .strb(strb), .b_ready_req(rr4), .rdata(rd4),
    .b_timeout(to4), .dbg_state(st4), .apb(bus4)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int to_of(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  function automatic bit exp_empty(input int d);
    return (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
  endfunction

  function automatic exp_t exp_head(input int d);
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic exp_t exp_pop(input int d);
    return (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
  endfunction

  function automatic slv_t slv_pop(input int d);
    slv_t s;
    s = '0;
    if (d == 0 && slv_q0.size() > 0) s = slv_q0.pop_front();
    if (d == 1 && slv_q1.size() > 0) s = slv_q1.pop_front();
    return s;
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, to_of(d), cyc, act, exp);
    end
  endtask

  // monitor + APB slave responder for one instance, evaluated on the falling edge
  task automatic mon(input int d, input logic psel, input logic pen, input logic pwr,
                     input logic [31:0] paddr, input logic [31:0] pwdata, input logic [2:0] pprot,
                     input logic [3:0] pstrb, input logic rr, input logic [31:0] rd, input logic to,
                     output logic rdy, output logic [31:0] prd);
    exp_t e;
    slv_t s;
    rdy = 1'b0;
    if (!rst_n) begin
      chk("rst_psel", d, psel, 0);
      chk("rst_penable", d, pen, 0);
      chk("rst_ready_req", d, rr, 0);
      chk("rst_rdata", d, rd, 0);
      chk("rst_timeout", d, to, 0);
      chk("rst_paddr", d, paddr, 0);
      chk("rst_pwdata", d, pwdata, 0);
      prev_rr[d] = 1'b0; prev_psel[d] = 1'b0; prev_pen[d] = 1'b0;
      cur_rd[d] = '0; acnt[d] = 0; slv_w[d] = 0; slv_prd[d] = '0;
      prd = '0;
      return;
    end
    if (rr != prev_rr[d]) begin
      if (exp_empty(d)) begin
        chk("spurious_ack", d, 1, 0);
      end else begin
        e = exp_pop(d);
        chk("done_cycle", d, cyc, e.done);
        chk("rdata", d, rd, e.rdata);
        chk("timeout_flag", d, to, e.to);
        cur_rd[d] = e.rdata;
      end
    end else begin
      chk("timeout_quiet", d, to, 0);
      chk("rdata_hold", d, rd, cur_rd[d]);
    end
    if (psel && !pen && !prev_psel[d]) begin
      if (exp_empty(d)) begin
        chk("spurious_start", d, 1, 0);
      end else begin
        e = exp_head(d);
        chk("start_cycle", d, cyc, e.start);
        chk("pwrite", d, pwr, e.wr);
        chk("paddr", d, paddr, e.addr);
        chk("pwdata", d, pwdata, e.wdata);
        chk("pprot", d, pprot, e.prot);
        chk("pstrb", d, pstrb, e.strb);
        s = slv_pop(d);
        slv_w[d] = s.w;
        slv_prd[d] = s.prd;
        start_cyc[d] = cyc;
      end
    end
    if (pen && !prev_pen[d]) begin
      chk("penable_cycle", d, cyc, start_cyc[d] + 1);
      chk("penable_psel", d, psel, 1);
    end
    if (!exp_empty(d)) begin
      e = exp_head(d);
      if (cyc > e.done + 30) begin
        chk("no_completion", d, cyc, e.done);
        e = exp_pop(d);
      end
    end
    if (psel && pen) begin
      rdy = (acnt[d] >= slv_w[d]);
      acnt[d]++;
    end else begin
      acnt[d] = 0;
    end
    prd = slv_prd[d];
    prev_rr[d] = rr;
    prev_psel[d] = psel;
    prev_pen[d] = pen;
  endtask

  always @(negedge clk) begin : monitor
    logic        r;
    logic [31:0] p;
    mon(0, bus8.b_psel, bus8.b_penable, bus8.b_pwrite, bus8.b_paddr, bus8.b_pwdata,
        bus8.b_pprot, bus8.b_pstrb, rr8, rd8, to8, r, p);
    bus8.b_pready = r;
    bus8.b_prdata = p;
    mon(1, bus4.b_psel, bus4.b_penable, bus4.b_pwrite, bus4.b_paddr, bus4.b_pwdata,
        bus4.b_pprot, bus4.b_pstrb, rr4, rd4, to4, r, p);
    bus4.b_pready = r;
    bus4.b_prdata = p;
  end

  // driver: issue one request; w = PREADY-low ACCESS cycles the slave inserts
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] pr, input logic [3:0] sb, input int w, input logic [31:0] prd);
    exp_t e;
    slv_t s;
    write = wr; addr = a; wdata = wd; prot = pr; strb = sb;
    a_apb_req = ~a_apb_req;
    s.w = w;
    s.prd = prd;
    for (int d = 0; d < 2; d++) begin
      e.wr = wr; e.addr = a; e.wdata = wd; e.prot = pr; e.strb = sb;
      e.start = (cyc + 3 > last_done[d] + 1) ? cyc + 3 : last_done[d] + 1;
      e.to = (w >= to_of(d));
      e.done = e.start + 2 + (e.to ? to_of(d) - 1 : w);
      e.rdata = wr ? mrd[d] : (e.to ? 32'hDEAD_BEEF : prd);
      mrd[d] = e.rdata;
      last_done[d] = e.done;
      if (d == 0) begin exp_q0.push_back(e); slv_q0.push_back(s); end
      else begin exp_q1.push_back(e); slv_q1.push_back(s); end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_pen();
    for (int i = 0; i < 50; i++) begin
      if (bus8.b_penable) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_apb_req = 1'b0;
    exp_q0.delete(); exp_q1.delete(); slv_q0.delete(); slv_q1.delete();
    for (int d = 0; d < 2; d++) begin last_done[d] = 0; mrd[d] = '0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic        wr;
    int          w;
    bus8.b_pready = 1'b0; bus8.b_prdata = '0;
    bus4.b_pready = 1'b0; bus4.b_prdata = '0;
    write = 1'b0; addr = '0; wdata = '0; prot = '0; strb = '0;
    #1 do_reset();

    issue(1'b1, 32'h10, 32'hA5A5_0001, 3'd0, 4'hF, 0, 32'h0);
    drain();
    issue(1'b0, 32'h20, 32'h0, 3'd1, 4'h0, 3, 32'h1234_5678);
    drain();
    issue(1'b1, 32'h30, 32'h0000_3030, 3'd2, 4'h3, 2, 32'h0);
    wait_pen();
    issue(1'b0, 32'h34, 32'h0, 3'd3, 4'h0, 1, 32'h5555_AAAA);
    drain();
    issue(1'b0, 32'h40, 32'h0, 3'd0, 4'h0, 20, 32'h0BAD_0BAD);
    drain();
    issue(1'b0, 32'h44, 32'h0, 3'd0, 4'h0, 3, 32'hCAFE_0001);
    drain();
    issue(1'b0, 32'h48, 32'h0, 3'd0, 4'h0, 7, 32'hCAFE_0002);
    drain();
    issue(1'b1, 32'h4C, 32'h7777_0000, 3'd5, 4'h1, 9, 32'h0);
    drain();

    issue(1'b0, 32'h50, 32'h0, 3'd0, 4'h0, 3, 32'h9999_0000);
    wait_pen();
    do_reset();
    issue(1'b1, 32'h60, 32'h6060_6060, 3'd4, 4'hC, 0, 32'h0);
    drain();
    issue(1'b0, 32'h64, 32'h0, 3'd0, 4'h0, 1, 32'h0101_0202);
    drain();

    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 3);
      issue(wr, $urandom, $urandom, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), w, $urandom);
      if ($urandom_range(0, 2) == 0) begin
        wait_pen();
        wr = 1'($urandom_range(0, 1));
        issue(wr, $urandom, $urandom, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
              $urandom_range(0, 5), $urandom);
      end
      drain();
    end

    repeat (40) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
